// File: rtl/conv_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_encoder: rate-1/2, K=7 tail-biting convolutional encoder (171/133).   |
// | Optional double buffering with CONV_ENC_PINGPONG_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_encoder #(
  parameter int BLOCK_LEN = 96
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output logic out_x,
  output logic out_y,
  output logic block_done
);

  localparam int              c_CW   = $clog2(BLOCK_LEN);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(BLOCK_LEN - 1);

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    ENCODE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_wr_cnt;
  logic [c_CW-1:0] r_rd_cnt;
  logic [5:0]      r_s;          // r_s[0] = s0 (most recent bit)
  logic [5:0]      w_load_s;
  logic [5:0]      w_next_s;
  logic [5:0]      w_preload_s;
  logic            w_preload;
  logic            w_next_avail;
  logic            w_buf_free;
  logic            w_in_fire;
  logic            w_in_last;
  logic            w_out_fire;
  logic            w_out_last;
  logic            w_u;

`ifdef CONV_ENC_PINGPONG_EN
  logic [BLOCK_LEN-1:0] r_buf [2];
  logic [1:0]           r_full;
  logic                 r_wsel;
  logic                 r_rsel;
  logic                 w_asel;

  assign w_asel     = ~r_rsel;
  assign w_u        = r_buf[r_rsel][r_rd_cnt];
  assign w_buf_free = ~r_full[r_wsel];
  // s0 comes straight from the bit completing the block; it is not in the buffer yet
  assign w_load_s   = {r_buf[r_wsel][BLOCK_LEN-6], r_buf[r_wsel][BLOCK_LEN-5],
                       r_buf[r_wsel][BLOCK_LEN-4], r_buf[r_wsel][BLOCK_LEN-3],
                       r_buf[r_wsel][BLOCK_LEN-2], in_bit};
  // Alternate buffer either already full or completing on this very edge
  assign w_next_avail = r_full[w_asel] | w_in_last;
  assign w_next_s     = r_full[w_asel] ?
                        {r_buf[w_asel][BLOCK_LEN-6], r_buf[w_asel][BLOCK_LEN-5],
                         r_buf[w_asel][BLOCK_LEN-4], r_buf[w_asel][BLOCK_LEN-3],
                         r_buf[w_asel][BLOCK_LEN-2], r_buf[w_asel][BLOCK_LEN-1]} :
                        w_load_s;

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_wsel][r_wr_cnt] <= in_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 2'b00;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
    end else begin
      if (w_in_last) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= ~r_wsel;
      end
      if (w_out_last) begin
        r_full[r_rsel] <= 1'b0;
      end
      if (r_state == LOAD && w_in_last) begin
        r_rsel <= r_wsel;
      end else if (w_out_last) begin
        r_rsel <= w_asel;
      end
    end
  end
`else
  logic [BLOCK_LEN-1:0] r_buf;

  assign w_u          = r_buf[r_rd_cnt];
  assign w_buf_free   = (r_state == LOAD);
  assign w_load_s     = {r_buf[BLOCK_LEN-6], r_buf[BLOCK_LEN-5], r_buf[BLOCK_LEN-4],
                         r_buf[BLOCK_LEN-3], r_buf[BLOCK_LEN-2], in_bit};
  assign w_next_avail = 1'b0;
  assign w_next_s     = w_load_s;

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_wr_cnt] <= in_bit;
    end
  end
`endif

  assign in_ready   = w_buf_free;
  assign out_valid  = (r_state == ENCODE);
  assign w_in_fire  = in_valid & in_ready;
  assign w_in_last  = w_in_fire & (r_wr_cnt == c_LAST);
  assign w_out_fire = out_valid & out_ready;
  assign w_out_last = w_out_fire & (r_rd_cnt == c_LAST);
  assign block_done = w_out_last;
  assign out_x      = out_valid & (w_u ^ r_s[0] ^ r_s[1] ^ r_s[2] ^ r_s[5]);
  assign out_y      = out_valid & (w_u ^ r_s[1] ^ r_s[2] ^ r_s[4] ^ r_s[5]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_preload   = 1'b0;
    w_preload_s = w_load_s;
    case (r_state)
      LOAD: begin
        if (w_in_last) begin
          w_state_nxt = ENCODE;
          w_preload   = 1'b1;
        end
      end
      ENCODE: begin
        if (w_out_last) begin
          if (w_next_avail) begin
            w_preload   = 1'b1;
            w_preload_s = w_next_s;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_s      <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= w_in_last ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_out_fire) begin
        r_rd_cnt <= w_out_last ? '0 : r_rd_cnt + 1'b1;
      end
      if (w_preload) begin
        r_s <= w_preload_s;
      end else if (w_out_fire) begin
        r_s <= {r_s[4:0], w_u};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for conv_encoder: known-answer vectors, gaps, stalls, reset, back-to-back blocks.
module tb_conv_encoder;

  localparam int              BLOCK_LEN = 96;
  localparam logic [95:0]     c_VEC     = 96'h558AC4A53A1724E163AC2BF9;
  localparam logic [191:0]    c_CODE    = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_ready;
  logic out_valid;
  logic out_x;
  logic out_y;
  logic block_done;

  int checks;
  int errors;

  logic [383:0] got;
  int nout;
  int ndone;
  int nvalid;
  int first_valid;
  int last_valid;
  int in_last_cyc;
  int rdy_in_enc;
  int bits_sent;

  always #5 clk = ~clk;

  conv_encoder #(.BLOCK_LEN(BLOCK_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .block_done (block_done)
  );

  task automatic chk_v(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives nbits of data (MSB first) and collects pairs until stop_pairs have transferred.
  task automatic run(input logic [383:0] data, input int nbits, input bit gaps,
                     input bit stalls, input int stop_pairs);
    int   cyc;
    int   stalls_left;
    logic hold_chk;
    logic hold_x;
    logic hold_y;
    logic exp_done;
    cyc         = 0;
    stalls_left = stalls ? 10 : 0;
    hold_chk    = 1'b0;
    hold_x      = 1'b0;
    hold_y      = 1'b0;
    got         = '0;
    nout        = 0;
    ndone       = 0;
    nvalid      = 0;
    first_valid = -1;
    last_valid  = -1;
    in_last_cyc = -100;
    rdy_in_enc  = 0;
    bits_sent   = 0;
    while (nout < stop_pairs && cyc < 3000) begin
      @(negedge clk);
      in_valid  = (bits_sent < nbits) && (!gaps || (cyc % 2 == 1));
      in_bit    = (bits_sent < nbits) ? data[383 - bits_sent] : 1'b0;
      out_ready = 1'b1;
      if (out_valid && stalls_left > 0 &&
          (($urandom_range(0, 3) == 0) || (stop_pairs - nout <= stalls_left))) begin
        out_ready   = 1'b0;
        stalls_left = stalls_left - 1;
      end
      #1;
      if (hold_chk) begin
        chk_v("stall_hold", 384'({out_valid, out_x, out_y}), 384'({1'b1, hold_x, hold_y}));
      end
      hold_chk = out_valid && !out_ready;
      hold_x   = out_x;
      hold_y   = out_y;
      if (out_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
        if (in_ready) rdy_in_enc++;
      end
      exp_done = out_valid && out_ready && ((nout % BLOCK_LEN) == BLOCK_LEN - 1);
      if (exp_done || block_done) begin
        chk_v("block_done_pos", 384'(block_done), 384'(exp_done));
      end
      if (block_done) ndone++;
      if (out_valid && out_ready) begin
        if (nout < 192) begin
          got[383 - 2*nout] = out_x;
          got[382 - 2*nout] = out_y;
        end
        nout++;
      end
      if (in_valid && in_ready) begin
        bits_sent++;
        if (bits_sent == BLOCK_LEN) in_last_cyc = cyc;
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      chk_i("run_timeout_pairs", nout, stop_pairs);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_v("reset_state", 384'({in_ready, out_valid, out_x, out_y, block_done}), 384'(5'b10000));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_v("post_reset_idle", 384'({in_ready, out_valid}), 384'(2'b10));

    // Known-answer block, continuous flow
    run({c_VEC, 288'b0}, 96, 1'b0, 1'b0, 96);
    chk_v("kat_stream", got, {c_CODE, 192'b0});
    chk_i("kat_done_cnt", ndone, 1);
    chk_i("kat_valid_cycles", nvalid, 96);
    chk_i("kat_first_latency", first_valid, in_last_cyc + 1);
`ifndef CONV_ENC_PINGPONG_EN
    chk_i("kat_in_ready_enc", rdy_in_enc, 0);
`endif

    // All-zero block
    run(384'b0, 96, 1'b0, 1'b0, 96);
    chk_v("zero_stream", got, 384'b0);
    chk_i("zero_valid_cycles", nvalid, 96);
    chk_i("zero_done_cnt", ndone, 1);

    // Input gaps every other cycle plus output stalls
    run({c_VEC, 288'b0}, 96, 1'b1, 1'b1, 96);
    chk_v("gap_stall_stream", got, {c_CODE, 192'b0});
    chk_i("gap_stall_done_cnt", ndone, 1);
    chk_i("gap_stall_valid_cycles", nvalid, 106);

    // Reset in the middle of encoding, then resend
    run({c_VEC, 288'b0}, 96, 1'b0, 1'b0, 50);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #1;
    chk_v("midreset_outputs", 384'({in_ready, out_valid, out_x, out_y, block_done}), 384'(5'b10000));
    @(negedge clk);
    #1;
    chk_v("midreset_outputs_2", 384'({in_ready, out_valid, out_x, out_y, block_done}), 384'(5'b10000));
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    run({c_VEC, 288'b0}, 96, 1'b0, 1'b0, 96);
    chk_v("after_reset_stream", got, {c_CODE, 192'b0});
    chk_i("after_reset_done_cnt", ndone, 1);

    // Two blocks back to back: known vector then all ones
    run({c_VEC, {96{1'b1}}, 192'b0}, 192, 1'b0, 1'b0, 192);
    chk_v("b2b_stream", got, {c_CODE, {192{1'b1}}});
    chk_i("b2b_done_cnt", ndone, 2);
    chk_i("b2b_valid_cycles", nvalid, 192);
`ifdef CONV_ENC_PINGPONG_EN
    chk_i("b2b_no_bubble", last_valid - first_valid + 1, 192);
`else
    chk_i("b2b_in_ready_enc", rdy_in_enc, 0);
`endif

    @(negedge clk);
    #1;
    chk_v("final_idle", 384'({in_ready, out_valid, block_done}), 384'(3'b100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter: BLOCK_LEN, 96, bits per FEC block; legal range 7..127.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream (randomizer) bit valid.
REQ-005 in_bit  input  1  serial data bit, first bit of block first.
REQ-006 in_ready  output  1  block can accept a bit this cycle.
REQ-007 out_ready  input  1  downstream accepts the output pair this cycle.
REQ-008 out_valid  output  1  out_x/out_y valid.
REQ-009 out_x  output  1  G1 = 171 (octal) coded bit.
REQ-010 out_y  output  1  G2 = 133 (octal) coded bit.
REQ-011 block_done  output  1  one-cycle pulse on transfer of the last output pair of a block.

Function
REQ-012 Rate-1/2, K=7, tail-biting convolutional encoder; one input bit yields one (out_x, out_y) pair.
REQ-013 Input transfer only when in_valid && in_ready; bit is written to buffer at index wr_cnt, 0..BLOCK_LEN-1.
REQ-014 FSM states: LOAD (fill buffer), ENCODE (emit pairs); reset enters LOAD with wr_cnt = 0.
REQ-015 LOAD -> ENCODE on the cycle the BLOCK_LEN-th bit transfers; encoder register preloaded that same edge.
REQ-016 Tail-biting preload: s0..s5 = buffer bits BLOCK_LEN-1 .. BLOCK_LEN-6 (s0 = last bit of block).
REQ-017 ENCODE: with u = buffer[rd_cnt], out_x = u^s0^s1^s2^s5, out_y = u^s1^s2^s4^s5; combinational from registered state.
REQ-018 Output transfer when out_valid && out_ready; on transfer, shift s (s0 <= u, sK <= sK-1) and rd_cnt increments.
REQ-019 out_ready low: out_valid, out_x, out_y and all encoder state held unchanged.
REQ-020 Transfer of pair rd_cnt = BLOCK_LEN-1: block_done pulses, rd_cnt wraps to 0, FSM returns to LOAD (or stays ENCODE per REQ-026).
REQ-021 out_valid is high throughout ENCODE, low in LOAD; first pair valid the cycle after the last input transfer.
REQ-022 Gaps in in_valid tolerated at any position; wr_cnt holds.
REQ-023 Concatenated output stream x0 y0 x1 y1 ... equals the standard 2*BLOCK_LEN-bit tail-biting codeword.

Reset
REQ-024 reset low, asynchronously: FSM = LOAD, wr_cnt = rd_cnt = 0, s = 0, in_ready = 1, out_valid = 0, out_x = out_y = 0, block_done = 0.
REQ-025 Reset mid-LOAD or mid-ENCODE discards the partial block; after deassertion the next accepted bit is bit 0 of a new block.

Configuration
REQ-026 Macro CONV_ENC_PINGPONG_EN defined: two BLOCK_LEN buffers; in_ready stays high during ENCODE while the alternate buffer is not full; a full alternate buffer at REQ-020 makes the FSM stay in ENCODE on it with no out_valid bubble; in_ready low only when both buffers are full.
REQ-027 Macro undefined: single buffer; in_ready = 1 only in LOAD, 0 throughout ENCODE.

Verification
REQ-028 96 bits of 558AC4A53A1724E163AC2BF9 MSB first, out_ready = 1 -> 192-bit stream 2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA, one block_done pulse.
REQ-029 96 zero bits -> 192 zero output bits; out_valid high exactly 96 cycles.
REQ-030 Same vector with in_valid toggled every other cycle and out_ready low for 10 random cycles -> identical 192-bit stream, outputs stable while out_ready low.
REQ-031 Reset asserted after 50 output pairs, then vector of REQ-028 resent -> outputs zero during reset, then full correct 192-bit stream.
REQ-032 Two blocks back-to-back (REQ-028 vector, then all-ones) -> both codewords correct; with CONV_ENC_PINGPONG_EN no out_valid gap between blocks, without it in_ready low for all 96 ENCODE cycles.
